lifo_stack: RTL

- Synchronous LIFO stack built from a register array and a saturating up/down stack pointer.
- Sits in the same pointer/counter family as the wrapping counters. Used downstream of producers that need last-in-first-out reordering, such as return-address stacks, undo buffers and reverse-order readout.
- Show-ahead read port: the top entry is always visible, and a pop consumes it.
- Supports power-of-2 and non-power-of-2 depths.

---
 rtl/lifo_stack_pkg.sv | 18 +
 rtl/lifo_stack_storage.sv | 35 +++
 rtl/lifo_stack.sv | 132 +++++++++++++
 3 files changed

// File: rtl/lifo_stack_pkg.sv
// Shared helpers for the lifo_stack slice: width derivation for the pointer and
// the index buses.
package lifo_stack_pkg;

  // Ceiling log2. The derived widths rely on clog2(1) == 0.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/lifo_stack_storage.sv
// DEPTH x WIDTH register array for lifo_stack: one synchronous write port and
// one combinational read port. Contents are intentionally not reset.
module lifo_stack_storage #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clock,
  input  logic                  write_enable,
  input  logic [DEPTH_LOG2-1:0] write_index,
  input  logic [WIDTH-1:0]      write_data,
  input  logic [DEPTH_LOG2-1:0] read_index,
  output logic [WIDTH-1:0]      read_data
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Write port; indices past the last entry (non-pow2 depths) are dropped.
  always_ff @(posedge clock) begin
    if (write_enable && (int'(write_index) < DEPTH)) begin
      mem_r[write_index] <= write_data;
    end
  end

  // Read port; an out-of-range index reads as zero instead of indexing off the array.
  always_comb begin
    read_data = {WIDTH{1'b0}};
    if (int'(read_index) < DEPTH) begin
      read_data = mem_r[read_index];
    end else begin
      read_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/lifo_stack.sv
// Synchronous LIFO stack with a saturating pointer and a show-ahead read port.
// Define LIFO_STACK_ERROR_FLAGS_EN to add sticky overflow/underflow outputs.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int DEPTH_LOG2  = clog2(DEPTH),
  parameter int LEVEL_WIDTH = clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   write_enable,
  input  logic [WIDTH-1:0]       write_data,
  output logic                   full,
  input  logic                   read_enable,
  output logic [WIDTH-1:0]       read_data,
  output logic                   empty,
  output logic [LEVEL_WIDTH-1:0] level
`ifdef LIFO_STACK_ERROR_FLAGS_EN
  ,
  output logic                   overflow,
  output logic                   underflow
`endif
);

  localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] ONE_LEVEL  = LEVEL_WIDTH'(1);

  logic [LEVEL_WIDTH-1:0] sp_r;
  logic [LEVEL_WIDTH-1:0] sp_next_s;
  logic                   mem_write_s;
  logic [DEPTH_LOG2-1:0]  mem_write_index_s;
  logic [DEPTH_LOG2-1:0]  push_index_s;
  logic [DEPTH_LOG2-1:0]  top_index_s;
  logic [WIDTH-1:0]       top_data_s;

  // Flags are decodes of the pointer register only, never of the request inputs.
  assign empty        = (sp_r == {LEVEL_WIDTH{1'b0}});
  assign full         = (sp_r == FULL_LEVEL);
  assign level        = sp_r;
  assign push_index_s = DEPTH_LOG2'(sp_r);
  assign top_index_s  = DEPTH_LOG2'(sp_r - ONE_LEVEL);
  assign read_data    = empty ? {WIDTH{1'b0}} : top_data_s;

  // Request qualification: illegal pushes/pops fall through with no state change.
  always_comb begin
    mem_write_s       = 1'b0;
    mem_write_index_s = push_index_s;
    sp_next_s         = sp_r;
    case ({write_enable, read_enable})
      2'b10: begin
        if (!full) begin
          mem_write_s = 1'b1;
          sp_next_s   = sp_r + ONE_LEVEL;
        end else begin
          mem_write_s = 1'b0;
          sp_next_s   = sp_r;
        end
      end
      2'b01: begin
        if (!empty) begin
          sp_next_s = sp_r - ONE_LEVEL;
        end else begin
          sp_next_s = sp_r;
        end
      end
      2'b11: begin
        // Replace-top is legal even when full; on empty only the push survives.
        mem_write_s = 1'b1;
        if (!empty) begin
          mem_write_index_s = top_index_s;
          sp_next_s         = sp_r;
        end else begin
          mem_write_index_s = push_index_s;
          sp_next_s         = sp_r + ONE_LEVEL;
        end
      end
      default: begin
        mem_write_s       = 1'b0;
        mem_write_index_s = push_index_s;
        sp_next_s         = sp_r;
      end
    endcase
  end

  // Stack pointer, cleared asynchronously so stale entries are hidden at once.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sp_r <= {LEVEL_WIDTH{1'b0}};
    end else begin
      sp_r <= sp_next_s;
    end
  end

  lifo_stack_storage #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_storage (
    .clock        (clock),
    .write_enable (mem_write_s),
    .write_index  (mem_write_index_s),
    .write_data   (write_data),
    .read_index   (top_index_s),
    .read_data    (top_data_s)
  );

`ifdef LIFO_STACK_ERROR_FLAGS_EN
  logic overflow_r;
  logic underflow_r;

  // Sticky error flags; a replace-top while full is not an overflow.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (write_enable && !read_enable && full) begin
        overflow_r <= 1'b1;
      end
      if (read_enable && !write_enable && empty) begin
        underflow_r <= 1'b1;
      end
    end
  end

  assign overflow  = overflow_r;
  assign underflow = underflow_r;
`endif

endmodule
